sca_wb_master: RTL and testbench
================================

Name: sca_wb_master

Overview:
Wishbone classic single-cycle initiator for the SCA channel model. It turns one command-side request (read/write, address, data, byte select) into exactly one Wishbone cycle towards a channel slave such as the DAC register interface. It returns the read data or a completion/error status on a response handshake. It sits between the SCA command decoder and each channel's Wishbone slave port, and includes a bus-timeout watchdog.

Parameters:
ADR_W, 5, Wishbone address width
TIMEOUT, 15, maximum cycles stb may stay high without ack/err before the cycle is aborted (range 1..255)
CNT_W, 8, timeout counter width; must satisfy 2**CNT_W > TIMEOUT

Ports:
wb_clk_in  in  1  clock
wb_rst_in  in  1  reset, asynchronous, active-high
cmd_valid_in  in  1  command request valid
cmd_ready_out  out  1  master can accept a command
cmd_we_in  in  1  1 = write, 0 = read
cmd_adr_in  in  ADR_W  target register address
cmd_dat_in  in  32  write data
cmd_sel_in  in  4  byte selects
rsp_valid_out  out  1  response valid
rsp_ready_in  in  1  response consumed
rsp_dat_out  out  32  read data; 0 for writes and errors
rsp_err_out  out  2  00 ok, 01 slave err, 10 timeout
wb_adr_out  out  ADR_W  Wishbone address
wb_dat_out  out  32  Wishbone write data
wb_sel_out  out  4  Wishbone byte select
wb_we_out  out  1  Wishbone write enable
wb_stb_out  out  1  Wishbone strobe
wb_cyc_out  out  1  Wishbone cycle
wb_dat_in  in  32  Wishbone read data
wb_ack_in  in  1  Wishbone acknowledge
wb_err_in  in  1  Wishbone error

Behaviour:
- Clock and reset: clock wb_clk_in; reset wb_rst_in, asynchronous, active-high. All state and registered outputs are reset asynchronously: state=IDLE, wb_* outputs=0, rsp_valid_out=0, rsp_dat_out=0, rsp_err_out=00, timeout counter=0.
- cmd_ready_out is a combinational decode of state==IDLE. It is low during reset.
- FSM states:
  - IDLE: on a rising edge where cmd_valid_in & cmd_ready_out is high, capture adr/dat/sel/we into the wb_* output registers, set cyc=stb=1, clear the counter, and go to BUS. With no valid command, stay in IDLE.
  - BUS: cyc/stb stay high and the address/data/sel/we registers are held stable.
    - On an edge with wb_err_in=1: drop cyc/stb, set rsp_err=01, rsp_dat=0, go to RESP. err takes priority over a simultaneous ack.
    - Else on an edge with wb_ack_in=1: drop cyc/stb, set rsp_err=00. Set rsp_dat=wb_dat_in if it was a read, otherwise 0. Go to RESP.
    - Else, if counter==TIMEOUT-1: drop cyc/stb, set rsp_err=10, rsp_dat=0, go to RESP.
    - Otherwise increment the counter.
  - RESP: rsp_valid_out=1. rsp_dat_out and rsp_err_out are held until an edge with rsp_ready_in=1, then rsp_valid_out returns to 0 and the FSM returns to IDLE. No new command is accepted in the same cycle as the response handshake.
- Latency:
  - cyc/stb rise 1 cycle after the command handshake edge.
  - rsp_valid rises 1 cycle after the ack/err/timeout edge.
  - With a slave that acks one cycle after stb, command-accept to rsp_valid takes 3 edges.
- Single-cycle ack pulse compatibility: stb is deasserted at the same edge that samples ack, so a slave computing cyc&stb&~ack sees no second request.
- Late ack: an ack or err arriving in IDLE or RESP is ignored and does not change the response.
- wb_adr/dat/sel/we keep their last values after the cycle ends. Only cyc/stb return to 0.
- Reset asserted mid-BUS: cyc/stb drop immediately (asynchronously) and no response is produced.

Decomposition:
- Shared package sca_wb_pkg holds:
  - state encoding: IDLE=2'd0, BUS=2'd1, RESP=2'd2
  - error codes: RSP_OK=2'b00, RSP_BUSERR=2'b01, RSP_TIMEOUT=2'b10
- One natural sub-module, sca_wb_timeout: loadable counter with clear, enable and terminal-count output, parameterised by TIMEOUT and CNT_W.
- FSM and output registers stay in the top module.

Test Plan:
- Write with DAC-style slave (ack one cycle after stb): cmd we=1, adr=5'h01, dat=32'hA500_0000, sel=4'b1000 -> one stb pulse of 2 cycles, rsp_valid 3 edges after accept, rsp_err=00, rsp_dat=0, slave reg=8'hA5.
- Read back adr=5'h01 -> rsp_dat=32'hA500_0000, rsp_err=00; exactly one ack is seen per cycle.
- Timeout with a non-responding slave, TIMEOUT=15 -> stb high for exactly 15 cycles, then rsp_err=10, rsp_dat=0; cmd_ready returns high after the response handshake.
- wb_err_in and wb_ack_in asserted together in the first BUS cycle of a read -> rsp_err=01, rsp_dat=0.
- Back-pressure: rsp_ready_in held low for 6 cycles -> rsp_valid, rsp_dat and rsp_err stay stable, cmd_ready_out stays 0, and a pending cmd_valid is not accepted until the edge after the response handshake.
- Reset asserted two cycles into BUS -> cyc/stb go low without waiting for a clock edge, and no response is produced.

Source files
------------

// File: rtl/sca_wb_pkg.sv
// ============================================================================
// Module : sca_wb_pkg
// Brief  : Shared FSM state encoding and response codes for the SCA WB master.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sca_wb_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [1:0] RSP_OK      = 2'b00;
  localparam logic [1:0] RSP_BUSERR  = 2'b01;
  localparam logic [1:0] RSP_TIMEOUT = 2'b10;

endpackage

`default_nettype wire

// File: rtl/sca_wb_timeout.sv
// ============================================================================
// Module : sca_wb_timeout
// Brief  : Bus watchdog counter with clear, enable and terminal-count flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sca_wb_timeout #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] c_TC = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == c_TC);

endmodule

`default_nettype wire

// File: rtl/sca_wb_master.sv
// ============================================================================
// Module : sca_wb_master
// Brief  : Wishbone classic single-cycle initiator with response handshake.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sca_wb_master
  import sca_wb_pkg::*;
#(
  parameter int ADR_W   = 5,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic             wb_clk_in,
  input  logic             wb_rst_in,
  input  logic             cmd_valid_in,
  output logic             cmd_ready_out,
  input  logic             cmd_we_in,
  input  logic [ADR_W-1:0] cmd_adr_in,
  input  logic [31:0]      cmd_dat_in,
  input  logic [3:0]       cmd_sel_in,
  output logic             rsp_valid_out,
  input  logic             rsp_ready_in,
  output logic [31:0]      rsp_dat_out,
  output logic [1:0]       rsp_err_out,
  output logic [ADR_W-1:0] wb_adr_out,
  output logic [31:0]      wb_dat_out,
  output logic [3:0]       wb_sel_out,
  output logic             wb_we_out,
  output logic             wb_stb_out,
  output logic             wb_cyc_out,
  input  logic [31:0]      wb_dat_in,
  input  logic             wb_ack_in,
  input  logic             wb_err_in
);

  logic [1:0]       r_state;
  logic [ADR_W-1:0] r_adr;
  logic [31:0]      r_dat;
  logic [3:0]       r_sel;
  logic             r_we;
  logic             r_stb;
  logic             r_cyc;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_dat;
  logic [1:0]       r_rsp_err;

  logic w_accept;
  logic w_tc;
  logic w_cnt_en;

  // Ready is forced low while reset is held, even though the state is IDLE.
  assign cmd_ready_out = (r_state == IDLE) && !wb_rst_in;
  assign w_accept      = cmd_valid_in && cmd_ready_out;
  assign w_cnt_en      = (r_state == BUS) && !wb_err_in && !wb_ack_in && !w_tc;

  sca_wb_timeout #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .clk   (wb_clk_in),
    .rst   (wb_rst_in),
    .i_clr (w_accept),
    .i_en  (w_cnt_en),
    .o_tc  (w_tc)
  );

  always_ff @(posedge wb_clk_in or posedge wb_rst_in) begin
    if (wb_rst_in) begin
      r_state     <= IDLE;
      r_adr       <= '0;
      r_dat       <= '0;
      r_sel       <= '0;
      r_we        <= 1'b0;
      r_stb       <= 1'b0;
      r_cyc       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= RSP_OK;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_adr   <= cmd_adr_in;
            r_dat   <= cmd_dat_in;
            r_sel   <= cmd_sel_in;
            r_we    <= cmd_we_in;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_state <= BUS;
          end
        end
        BUS: begin
          // Strobe drops on the same edge that samples ack/err, so a slave
          // decoding cyc&stb&~ack never sees a second request.
          if (wb_err_in) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_err   <= RSP_BUSERR;
            r_rsp_dat   <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else if (wb_ack_in) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_err   <= RSP_OK;
            r_rsp_dat   <= r_we ? 32'd0 : wb_dat_in;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else if (w_tc) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_err   <= RSP_TIMEOUT;
            r_rsp_dat   <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_in) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wb_adr_out    = r_adr;
  assign wb_dat_out    = r_dat;
  assign wb_sel_out    = r_sel;
  assign wb_we_out     = r_we;
  assign wb_stb_out    = r_stb;
  assign wb_cyc_out    = r_cyc;
  assign rsp_valid_out = r_rsp_valid;
  assign rsp_dat_out   = r_rsp_dat;
  assign rsp_err_out   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_sca_wb_master.sv
// ============================================================================
// Module : tb_sca_wb_master
// Brief  : Self-checking bench for sca_wb_master with a DAC-style slave model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sca_wb_master;

  localparam int ADR_W   = 5;
  localparam int TIMEOUT = 15;

  typedef struct {
    logic        we;
    logic [4:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          mode;   // 0 ack next cycle, 1 silent, 2 err+ack together
    int          hold;   // cycles rsp_ready stays low
  } vec_t;

  typedef struct {
    logic [31:0] dat;
    logic [1:0]  err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_we = 1'b0;
  logic [ADR_W-1:0] cmd_adr = '0;
  logic [31:0]      cmd_dat = '0;
  logic [3:0]       cmd_sel = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_dat;
  logic [1:0]       rsp_err;
  logic [ADR_W-1:0] wb_adr;
  logic [31:0]      wb_dat_o;
  logic [3:0]       wb_sel;
  logic             wb_we;
  logic             wb_stb;
  logic             wb_cyc;
  logic [31:0]      wb_dat_i;
  logic             wb_ack;
  logic             wb_err;

  int n_vec  = 0;
  int n_fail = 0;
  int slave_mode = 0;
  logic force_ack = 1'b0;
  logic force_err = 1'b0;

  exp_t        exp_q[$];
  logic [31:0] shadow[32];
  vec_t        vecs[9];

  always #5 clk = ~clk;

  sca_wb_master #(.ADR_W(ADR_W), .TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .wb_clk_in     (clk),
    .wb_rst_in     (rst),
    .cmd_valid_in  (cmd_valid),
    .cmd_ready_out (cmd_ready),
    .cmd_we_in     (cmd_we),
    .cmd_adr_in    (cmd_adr),
    .cmd_dat_in    (cmd_dat),
    .cmd_sel_in    (cmd_sel),
    .rsp_valid_out (rsp_valid),
    .rsp_ready_in  (rsp_ready),
    .rsp_dat_out   (rsp_dat),
    .rsp_err_out   (rsp_err),
    .wb_adr_out    (wb_adr),
    .wb_dat_out    (wb_dat_o),
    .wb_sel_out    (wb_sel),
    .wb_we_out     (wb_we),
    .wb_stb_out    (wb_stb),
    .wb_cyc_out    (wb_cyc),
    .wb_dat_in     (wb_dat_i),
    .wb_ack_in     (wb_ack),
    .wb_err_in     (wb_err)
  );

  // Slave: registered ack one cycle after stb, byte-enabled register file.
  logic [31:0] smem[32];
  logic        s_ack_r;
  logic [31:0] s_rdat;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ack_r <= 1'b0;
      s_rdat  <= '0;
      for (int i = 0; i < 32; i++) smem[i] <= '0;
    end else begin
      s_ack_r <= 1'b0;
      if (slave_mode == 0 && wb_cyc && wb_stb && !s_ack_r) begin
        s_ack_r <= 1'b1;
        s_rdat  <= smem[wb_adr];
        if (wb_we)
          for (int b = 0; b < 4; b++)
            if (wb_sel[b]) smem[wb_adr][8*b +: 8] <= wb_dat_o[8*b +: 8];
      end
    end
  end

  assign wb_ack   = s_ack_r | (slave_mode == 2 && wb_cyc && wb_stb) | force_ack;
  assign wb_err   = (slave_mode == 2 && wb_cyc && wb_stb) | force_err;
  assign wb_dat_i = s_rdat;

  int stb_cnt = 0;
  int ack_cnt = 0;
  always @(posedge clk) begin
    if (wb_stb) stb_cnt <= stb_cnt + 1;
    if (wb_stb && wb_cyc && wb_ack) ack_cnt <= ack_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic start_cmd(input vec_t v);
    exp_t e;
    slave_mode = v.mode;
    cmd_we = v.we; cmd_adr = v.adr; cmd_dat = v.dat; cmd_sel = v.sel;
    cmd_valid = 1'b1;
    if (v.mode == 1) begin
      e.dat = 32'd0; e.err = 2'b10;
    end else if (v.mode == 2) begin
      e.dat = 32'd0; e.err = 2'b01;
    end else if (v.we) begin
      for (int b = 0; b < 4; b++)
        if (v.sel[b]) shadow[v.adr][8*b +: 8] = v.dat[8*b +: 8];
      e.dat = 32'd0; e.err = 2'b00;
    end else begin
      e.dat = shadow[v.adr]; e.err = 2'b00;
    end
    exp_q.push_back(e);
  endtask

  task automatic accept_and_wait(input vec_t v);
    int s0, a0, lat, exp_lat;
    exp_t e;
    s0 = stb_cnt; a0 = ack_cnt;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("cyc_after_accept", {31'd0, wb_cyc}, 32'd1);
    check("adr_driven", {27'd0, wb_adr}, {27'd0, v.adr});
    check("we_driven", {31'd0, wb_we}, {31'd0, v.we});
    if (v.we) check("dat_driven", wb_dat_o, v.dat);
    check("sel_driven", {28'd0, wb_sel}, {28'd0, v.sel});
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    exp_lat = (v.mode == 0) ? 2 : (v.mode == 1) ? TIMEOUT : 1;
    check("rsp_latency", lat, exp_lat);
    check("stb_cycles", stb_cnt - s0, exp_lat);
    check("ack_count", ack_cnt - a0, (v.mode == 1) ? 0 : 1);
    check("cyc_dropped", {31'd0, wb_cyc}, 32'd0);
    check("adr_held", {27'd0, wb_adr}, {27'd0, v.adr});
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("rsp_dat", rsp_dat, e.dat);
      check("rsp_err", {30'd0, rsp_err}, {30'd0, e.err});
    end
  endtask

  task automatic release_rsp(input int hold);
    logic [31:0] d0;
    logic [1:0]  e0;
    d0 = rsp_dat; e0 = rsp_err;
    for (int i = 0; i < hold; i++) begin
      force_ack = i[0];
      force_err = ~i[0];
      @(posedge clk); #1;
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_dat", rsp_dat, d0);
      check("hold_err", {30'd0, rsp_err}, {30'd0, e0});
      check("hold_ready_low", {31'd0, cmd_ready}, 32'd0);
    end
    force_ack = 1'b0; force_err = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("valid_cleared", {31'd0, rsp_valid}, 32'd0);
    check("ready_after_rsp", {31'd0, cmd_ready}, 32'd1);
    check("no_cycle_on_handshake", {31'd0, wb_cyc}, 32'd0);
  endtask

  initial begin
    vec_t v;
    int seen;
    vecs[0] = '{1'b1, 5'h01, 32'hA500_0000, 4'b1000, 0, 0};
    vecs[1] = '{1'b0, 5'h01, 32'h0,         4'b1111, 0, 0};
    vecs[2] = '{1'b0, 5'h03, 32'h0,         4'b1111, 1, 0};
    vecs[3] = '{1'b0, 5'h01, 32'h0,         4'b1111, 2, 0};
    vecs[4] = '{1'b1, 5'h02, 32'h1234_5678, 4'b0011, 0, 6};
    vecs[5] = '{1'b0, 5'h02, 32'h0,         4'b1111, 0, 0};
    vecs[6] = '{1'b1, 5'h01, 32'hFFFF_FFFF, 4'b0101, 0, 2};
    vecs[7] = '{1'b0, 5'h01, 32'h0,         4'b1111, 0, 0};
    vecs[8] = '{1'b1, 5'h05, 32'hCAFE_F00D, 4'b1111, 1, 0};
    for (int i = 0; i < 32; i++) shadow[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {31'd0, cmd_ready}, 32'd0);
    check("reset_cyc_stb", {30'd0, wb_cyc, wb_stb}, 32'd0);
    check("reset_rsp", {rsp_valid, rsp_err, rsp_dat[28:0]}, 32'd0);
    check("reset_wb_regs", {wb_we, wb_sel, wb_adr} | wb_dat_o, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

    for (int i = 0; i < 9; i++) begin
      start_cmd(vecs[i]);
      accept_and_wait(vecs[i]);
      release_rsp(vecs[i].hold);
    end

    // Back-pressure with a command already waiting during RESP.
    v = '{1'b1, 5'h04, 32'hDEAD_BEEF, 4'b1111, 0, 0};
    start_cmd(v);
    accept_and_wait(v);
    v = '{1'b0, 5'h04, 32'h0, 4'b1111, 0, 0};
    start_cmd(v);
    release_rsp(6);
    check("pending_still_valid", {31'd0, cmd_valid}, 32'd1);
    accept_and_wait(v);
    release_rsp(0);

    // Reset two cycles into BUS against a silent slave.
    v = '{1'b0, 5'h07, 32'h0, 4'b1111, 1, 0};
    start_cmd(v);
    exp_q.delete();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("bus_started", {31'd0, wb_cyc}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_drop_cyc_stb", {30'd0, wb_cyc, wb_stb}, 32'd0);
    check("ready_low_in_reset", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (rsp_valid || wb_cyc) seen++;
    end
    check("no_rsp_after_reset", seen, 0);
    check("ready_after_abort", {31'd0, cmd_ready}, 32'd1);

    // Functional after the abort: write then read with cleared slave.
    v = '{1'b1, 5'h09, 32'h0000_00A5, 4'b0001, 0, 0};
    start_cmd(v); accept_and_wait(v); release_rsp(0);
    v = '{1'b0, 5'h09, 32'h0, 4'b1111, 0, 0};
    start_cmd(v); accept_and_wait(v); release_rsp(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
